serial_rx: RTL
==============

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 16, receive buffer entries (power of two, 4..64).
REQ-004 Parameter RTS_MARGIN, default 4, free entries below which RTS is deasserted.
REQ-005 i_clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous, active-high.
REQ-007 i_rx  input  1  asynchronous serial line, idle high, 8N1.
REQ-008 o_char  output  8  head-of-buffer byte to the terminal controller.
REQ-009 o_valid  output  1  o_char holds a valid byte.
REQ-010 i_ready  input  1  consumer accepts o_char this cycle.
REQ-011 o_rts_n  output  1  flow control to host: low = send allowed.
REQ-012 o_frame_err  output  1  one-cycle pulse, byte dropped for bad stop bit.
REQ-013 o_overrun  output  1  one-cycle pulse, byte dropped because buffer full.

Function
REQ-014 i_rx passes through a 2-flop synchronizer before any use; all references to "rx" below mean the synchronized value.
REQ-015 BIT_TICKS = CLK_HZ/BAUD (integer division; 104 at defaults); HALF_TICKS = BIT_TICKS/2.
REQ-016 Receiver FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE: on rx=0, load tick counter with HALF_TICKS-1 and enter START.
REQ-018 START: at counter zero, if rx=0, clear bit index and enter DATA with counter BIT_TICKS-1; if rx=1, treat as glitch and return to IDLE with no output.
REQ-019 DATA: at each counter zero, shift rx into the shift register LSB first and reload BIT_TICKS-1; after the 8th bit, enter STOP.
REQ-020 STOP: at counter zero, if rx=1, push the byte; if rx=0, pulse o_frame_err, discard the byte, and return to IDLE only after rx has been seen high (no re-triggering on a held break).
REQ-021 After a successful STOP sample, the FSM returns to IDLE in the same cycle, so a start bit may be detected half a bit early.
REQ-022 Buffer is first-word-fall-through: o_valid = not empty; o_char = head entry, combinationally stable while o_valid=1 and i_ready=0.
REQ-023 Pop occurs when o_valid & i_ready; the head advances on the next edge.
REQ-024 Latency: a byte pushed at edge N gives o_valid=1 after edge N+1 when the buffer was empty; no bypass path.
REQ-025 Push while full with no pop in that cycle: drop the byte, pulse o_overrun, leave contents unchanged.
REQ-026 Push while full with a pop in the same cycle: accept both; count unchanged.
REQ-027 Pointers wrap modulo FIFO_DEPTH; the count register is log2(FIFO_DEPTH)+1 bits wide.
REQ-028 o_rts_n is registered: 1 when free entries < RTS_MARGIN, else 0.
REQ-029 Error pulses never coincide with a push; both pulses are registered.

Reset
REQ-030 On i_rst: FSM=IDLE, counters, pointers and count=0, synchronizer flops=1.
REQ-031 Reset outputs: o_valid=0, o_frame_err=0, o_overrun=0, o_rts_n=0, o_char=8'h00.
REQ-032 Reset mid-frame or mid-handshake discards the partial byte and all buffered bytes; after release, reception restarts only on a new falling edge.

Structure
REQ-033 Shared package holds FSM state encodings and the default CLK_HZ/BAUD constants, also used by other serial blocks.
REQ-034 The buffer is one sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count); the bit FSM stays in serial_rx.

Verification
REQ-035 Send 8'h41 at 115200 with i_ready=1 -> o_valid pulses once with o_char=8'h41, no error pulses.
REQ-036 Drive a 3-cycle low glitch on i_rx -> no push, FSM back in IDLE, all outputs at reset values.
REQ-037 Send 8'h55 with stop bit forced low -> o_frame_err one pulse, o_valid stays 0; next good byte 8'h0D is received correctly.
REQ-038 Hold i_ready=0 and send 17 bytes 8'h30..8'h40 -> o_rts_n=1 after byte 13, o_overrun pulses on byte 17; draining yields 8'h30..8'h3F in order.
REQ-039 Full buffer, assert i_ready on the cycle the 17th byte pushes -> no o_overrun, count stays 16, last byte read is the new byte.
REQ-040 Assert i_rst during DATA bit 4 with 3 bytes buffered -> o_valid=0 at once; after release, the next full frame 8'h7E is the only byte output.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Definitions shared by the serial blocks: receiver FSM state encodings, default line timing.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned SERIAL_CLK_HZ = 32'd12_000_000;
  localparam int unsigned SERIAL_BAUD   = 32'd115_200;

  function automatic int unsigned ticks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: a write shows at the head after the next edge, no bypass.
// When full a push is dropped unless a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_dat;
  end

  assign o_dat   = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver into a FWFT buffer; a byte reaches o_valid two edges after its stop-bit sample.
// Consumer stalls via i_ready; host is throttled by o_rts_n, and bytes arriving to a full buffer are dropped.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = SERIAL_CLK_HZ,
  parameter int unsigned BAUD       = SERIAL_BAUD,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RTS_MARGIN = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_char,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_rts_n,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int unsigned BIT_TICKS  = ticks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CNT_W      = $clog2(BIT_TICKS);
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1;

  logic             rx_meta_q, rx_q;
  rx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             brk_q;
  logic             push_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             rts_n_q;

  logic [7:0]       fifo_dat;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0]    fifo_count, free_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_q      <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      brk_q       <= 1'b0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_q) begin
            cnt_q   <= CNT_W'(HALF_TICKS - 1);
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!rx_q) begin
            bit_idx_q <= '0;
            cnt_q     <= CNT_W'(BIT_TICKS - 1);
            state_q   <= ST_DATA;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            shift_q <= {rx_q, shift_q[7:1]};
            cnt_q   <= CNT_W'(BIT_TICKS - 1);
            if (bit_idx_q == 3'd7) state_q <= ST_STOP;
            else                   bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        ST_STOP: begin
          // After a bad stop bit, park here until the line is seen idle so a held break cannot retrigger.
          if (brk_q) begin
            if (rx_q) begin
              brk_q   <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (rx_q) begin
            push_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            frame_err_q <= 1'b1;
            brk_q       <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = i_ready && !fifo_empty;
  assign free_cnt = CW'(FIFO_DEPTH) - fifo_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_q <= 1'b0;
      rts_n_q   <= 1'b0;
    end else begin
      overrun_q <= push_q && fifo_full && !fifo_pop;
      rts_n_q   <= (free_cnt < CW'(RTS_MARGIN));
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_q),
    .i_dat   (shift_q),
    .i_pop   (fifo_pop),
    .o_dat   (fifo_dat),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid     = !fifo_empty;
  assign o_char      = fifo_empty ? 8'h00 : fifo_dat;
  assign o_rts_n     = rts_n_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;

endmodule
